// File: rtl/kbd_cmd_ctrl_if.sv
// Bus between the keyboard command controller, the PS/2 receiver and the
// processor port logic. The slave side is the controller itself.
interface kbd_cmd_ctrl_if #(
  parameter int FIFO_AW = 2
);
  // Receiver side
  logic               rx_done_tick;
  logic [7:0]         rx_data;
  logic               rx_en;
  // Processor side
  logic               cmd_rd;
  logic               cmd_valid;
  logic [3:0]         cmd_code;
  logic [FIFO_AW:0]   cmd_count;
  logic               overflow;
  logic               ovf_clr;

  modport master (
    output rx_done_tick, rx_data, cmd_rd, ovf_clr,
    input  rx_en, cmd_valid, cmd_code, cmd_count, overflow
  );

  modport slave (
    input  rx_done_tick, rx_data, cmd_rd, ovf_clr,
    output rx_en, cmd_valid, cmd_code, cmd_count, overflow
  );
endinterface

// File: rtl/kbd_cmd_ctrl.sv
// Keyboard command controller: tracks E0/F0 scan-code prefixes, turns key
// releases of eight keys into 4-bit commands and queues them in a small
// show-ahead FIFO read by the processor through a valid/pop handshake.
module kbd_cmd_ctrl #(
  parameter int FIFO_AW = 2,
  parameter int TIMEOUT = 1000000,
  parameter int TO_W    = 20
) (
  input  logic           clk,
  input  logic           reset,
  kbd_cmd_ctrl_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [TO_W-1:0]     to_cnt;
  logic                timeout_hit;
  logic                push;
  logic [3:0]          push_code;

  logic [3:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count, count_next;
  logic                empty, full, pop, push_ok, drop;
  logic                rx_en_q, overflow_q;

  // Map a released scan code to its command; 0 means "no command".
  function automatic logic [3:0] decode(input logic [7:0] code, input logic ext);
    logic [3:0] c;
    case (code)
      8'h75:   c = 4'd4;
      8'h74:   c = 4'd5;
      8'h6B:   c = 4'd6;
      8'h72:   c = 4'd7;
      8'h2B:   c = ext ? 4'd0 : 4'd1;
      8'h33:   c = ext ? 4'd0 : 4'd2;
      8'h2C:   c = ext ? 4'd0 : 4'd3;
      8'h76:   c = ext ? 4'd0 : 4'd8;
      default: c = 4'd0;
    endcase
    return c;
  endfunction

  // A partial prefix is abandoned once the idle counter reaches TIMEOUT-1.
  assign timeout_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT - 1));

  // Prefix state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and decode; a byte in the timeout cycle is still processed.
  always_comb begin
    // NOTE: every output of this block is given a default first so no
    // path leaves it unassigned, which would infer a latch.
    state_next = state;
    push_code  = 4'd0;
    if (bus.rx_done_tick) begin
      case (state)
        IDLE: begin
          if (bus.rx_data == 8'hE0)      state_next = EXT;
          else if (bus.rx_data == 8'hF0) state_next = BRK;
        end
        EXT:     state_next = (bus.rx_data == 8'hF0) ? EXT_BRK : IDLE;
        BRK: begin
          push_code  = decode(bus.rx_data, 1'b0);
          state_next = IDLE;
        end
        EXT_BRK: begin
          push_code  = decode(bus.rx_data, 1'b1);
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_next = IDLE;
    end
    push = (push_code != 4'd0);
  end

  // Idle counter: runs only while a prefix is pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      to_cnt <= '0;
    else if (state == IDLE || bus.rx_done_tick || timeout_hit)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  // FIFO handshake qualification and next occupancy.
  always_comb begin
    empty      = (count == '0);
    full       = (count == (FIFO_AW + 1)'(DEPTH));
    pop        = bus.cmd_rd && !empty;
    push_ok    = push && (!full || pop);
    drop       = push && full && !pop;
    count_next = count;
    if (push_ok && !pop)      count_next = count + 1'b1;
    else if (!push_ok && pop) count_next = count - 1'b1;
  end

  // FIFO pointers, occupancy, receiver enable and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rx_en_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      rx_en_q <= (count_next < (FIFO_AW + 1)'(DEPTH));
      if (drop)             overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count gates every read, so
    // stale entries are never visible.
    if (push_ok) mem[wr_ptr] <= push_code;
  end

  assign bus.cmd_valid = !empty;
  assign bus.cmd_code  = empty ? 4'd0 : mem[rd_ptr];
  assign bus.cmd_count = count;
  assign bus.overflow  = overflow_q;
  assign bus.rx_en     = rx_en_q;

endmodule

// File: tb/tb_kbd_cmd_ctrl.sv
// Directed bench for kbd_cmd_ctrl with hand-computed expectations.
module tb_kbd_cmd_ctrl;

  localparam int FIFO_AW = 2;
  localparam int TIMEOUT = 16;
  localparam int TO_W    = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  kbd_cmd_ctrl_if #(.FIFO_AW(FIFO_AW)) bus ();

  kbd_cmd_ctrl #(
    .FIFO_AW (FIFO_AW),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, ending 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle receiver strobe with a byte.
  task automatic send(input logic [7:0] b);
    bus.rx_data      = b;
    bus.rx_done_tick = 1'b1;
    step(1);
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
  endtask

  task automatic pop();
    bus.cmd_rd = 1'b1;
    step(1);
    bus.cmd_rd = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_en"},  32'(bus.rx_en),     32'd0);
    check({tag, "_valid"},  32'(bus.cmd_valid), 32'd0);
    check({tag, "_code"},   32'(bus.cmd_code),  32'd0);
    check({tag, "_count"},  32'(bus.cmd_count), 32'd0);
    check({tag, "_ovf"},    32'(bus.overflow),  32'd0);
  endtask

  // Pop and compare the expected head sequence.
  task automatic drain(input string tag, input logic [3:0] c0, input logic [3:0] c1,
                       input logic [3:0] c2, input logic [3:0] c3, input int n);
    logic [3:0] exp [4];
    exp[0] = c0; exp[1] = c1; exp[2] = c2; exp[3] = c3;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_head%0d", tag, i), 32'(bus.cmd_code), 32'(exp[i]));
      pop();
    end
    check({tag, "_empty"}, 32'(bus.cmd_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.rx_data      = 8'h00;
    bus.cmd_rd       = 1'b0;
    bus.ovf_clr      = 1'b0;

    // Reset state
    step(3);
    check_reset_vals("rst");
    reset = 1'b1;
    check("rx_en_pre_edge", 32'(bus.rx_en), 32'd0);
    step(1);
    check("rx_en_first_edge", 32'(bus.rx_en), 32'd1);

    // Basic release of F
    send(8'hF0);
    check("no_cmd_after_f0", 32'(bus.cmd_valid), 32'd0);
    send(8'h2B);
    check("f_valid", 32'(bus.cmd_valid), 32'd1);
    check("f_code",  32'(bus.cmd_code),  32'd1);
    check("f_count", 32'(bus.cmd_count), 32'd1);
    pop();
    check("f_popped_valid", 32'(bus.cmd_valid), 32'd0);
    check("f_popped_count", 32'(bus.cmd_count), 32'd0);
    check("f_popped_code",  32'(bus.cmd_code),  32'd0);

    // Extended make ignored, extended break and keypad break decoded
    send(8'hE0); send(8'h75);
    check("ext_make_ignored", 32'(bus.cmd_count), 32'd0);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h72); send(8'hF0); send(8'h72);
    send(8'hAA); send(8'hFA);
    check("two_cmds_count", 32'(bus.cmd_count), 32'd2);
    drain("ext", 4'd4, 4'd7, 4'd0, 4'd0, 2);

    // F0/E0 inside a break, and an extended-only-invalid code, produce nothing
    send(8'hF0); send(8'hE0);
    send(8'hE0); send(8'hF0); send(8'h2B);
    send(8'h75);
    check("bad_codes_none", 32'(bus.cmd_count), 32'd0);

    // Fill the FIFO
    send(8'hF0); send(8'h2C);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hF0); send(8'h76);
    send(8'hF0); send(8'h33);
    check("full_count", 32'(bus.cmd_count), 32'd4);
    check("full_rx_en", 32'(bus.rx_en),     32'd0);
    check("full_head",  32'(bus.cmd_code),  32'd3);
    check("full_ovf0",  32'(bus.overflow),  32'd0);
    send(8'hF0); send(8'h6B);
    check("drop_ovf",   32'(bus.overflow),  32'd1);
    check("drop_count", 32'(bus.cmd_count), 32'd4);
    check("drop_head",  32'(bus.cmd_code),  32'd3);
    pop();
    check("pop_rx_en",  32'(bus.rx_en),     32'd1);
    check("pop_count",  32'(bus.cmd_count), 32'd3);
    check("ovf_sticky", 32'(bus.overflow),  32'd1);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);
    drain("after_drop", 4'd5, 4'd8, 4'd2, 4'd0, 3);

    // Push and pop in the same cycle while full
    send(8'hF0); send(8'h2C);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hF0); send(8'h76);
    send(8'hF0); send(8'h33);
    send(8'hF0);
    bus.cmd_rd = 1'b1;
    send(8'h6B);
    bus.cmd_rd = 1'b0;
    check("pp_count", 32'(bus.cmd_count), 32'd4);
    check("pp_ovf",   32'(bus.overflow),  32'd0);
    check("pp_rx_en", 32'(bus.rx_en),     32'd0);
    drain("pp", 4'd5, 4'd8, 4'd2, 4'd6, 4);

    // Push and pop in the same cycle while empty: pop ignored
    send(8'hF0);
    bus.cmd_rd = 1'b1;
    send(8'h76);
    bus.cmd_rd = 1'b0;
    check("pe_count", 32'(bus.cmd_count), 32'd1);
    check("pe_code",  32'(bus.cmd_code),  32'd8);
    pop();

    // Timeout: expired prefix, early byte, byte on the timeout cycle
    send(8'hF0); step(TIMEOUT); send(8'h2B);
    check("to_expired", 32'(bus.cmd_count), 32'd0);
    send(8'hF0); step(TIMEOUT - 3); send(8'h2B);
    check("to_early_code", 32'(bus.cmd_code), 32'd1);
    pop();
    send(8'hF0); step(TIMEOUT - 1); send(8'h2B);
    check("to_edge_code", 32'(bus.cmd_code), 32'd1);
    pop();
    send(8'hE0); send(8'hF0); step(TIMEOUT); send(8'h75);
    check("to_ext_expired", 32'(bus.cmd_count), 32'd0);

    // Reset mid-sequence and mid-FIFO
    send(8'hF0); send(8'h2B);
    send(8'hE0); send(8'hF0);
    reset = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    step(2);
    check_reset_vals("mid_rst_hold");
    reset = 1'b1;
    step(1);
    check("rst2_rx_en", 32'(bus.rx_en), 32'd1);
    send(8'h75);
    check("rst2_no_cmd", 32'(bus.cmd_valid), 32'd0);
    send(8'hF0); send(8'h75);
    check("rst2_alive", 32'(bus.cmd_code), 32'd4);
    pop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_cmd_ctrl.md
# kbd_cmd_ctrl

Keyboard command controller that sits between the PS/2 receiver and the PicoBlaze port interface of the RTC controller. It gates the receiver through `rx_en`, tracks the scan-code prefix sequence (E0 / F0), converts key releases of the eight supported keys into 4-bit command codes, and buffers them in a small FIFO. The processor reads the FIFO through a valid/pop handshake.

## Interface
- `FIFO_AW`, 2: FIFO address width; depth = 2^FIFO_AW (4).
- `TIMEOUT`, 1000000: idle cycles, with no byte received, before a partial prefix is abandoned (10 ms at 100 MHz).
- `TO_W`, 20: width of the timeout counter; must satisfy 2^TO_W ≥ TIMEOUT.

Ports:
- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_done_tick`  in  1  one-cycle strobe from the PS/2 receiver; `rx_data` is valid in this cycle.
- `rx_data`  in  8  received scan-code byte.
- `rx_en`  out  1  receiver enable; registered.
- `cmd_rd`  in  1  pop strobe from the processor.
- `cmd_valid`  out  1  FIFO non-empty.
- `cmd_code`  out  4  head-of-FIFO command (show-ahead); 0 when empty.
- `cmd_count`  out  FIFO_AW+1  number of entries held.
- `overflow`  out  1  sticky flag: a command was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Prefix FSM. States advance only on `rx_done_tick`:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte stays in IDLE (make codes, FA, AA, EE, FE, 00, FF, E1 are ignored).
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE (extended make, ignored).
  - BRK: decode as non-extended, then -> IDLE.
  - EXT_BRK: decode as extended, then -> IDLE.
- Non-extended decode: 2B->1 (F), 33->2 (H), 2C->3 (T), 75->4 (up), 74->5 (right), 6B->6 (left), 72->7 (down), 76->8 (ESC). Keypad arrows are accepted regardless of NumLock.
- Extended decode: 75->4, 74->5, 6B->6, 72->7.
- Every other code, including E0 or F0 arriving in BRK or EXT_BRK, produces no command and returns the FSM to IDLE.
- Timeout:
  - The counter clears in IDLE and on every `rx_done_tick`.
  - In EXT, BRK and EXT_BRK it increments every cycle.
  - When it reaches TIMEOUT-1, the FSM goes to IDLE and the counter clears.
  - `rx_done_tick` in the same cycle as the timeout wins: the byte is processed in the current state.
- FIFO:
  - A decoded command is a push; `cmd_rd` while `cmd_valid` is high is a pop. `cmd_rd` while empty is ignored.
  - Push while full without a simultaneous pop: the command is dropped and `overflow` is set.
  - Push and pop in the same cycle when full: both are performed and the count is unchanged.
  - Push and pop in the same cycle when empty: the pop is ignored and the push is performed.
  - Pointers wrap modulo 2^FIFO_AW.
- `overflow` is set by a drop and cleared by `ovf_clr`. If both happen in the same cycle, set wins.
- `rx_en` is registered from the next-state count: 1 when the next count < depth, 0 when the FIFO will be full. It re-asserts the cycle after a pop from full.
- Reset values:
  - FSM = IDLE; pointers, count and timeout counter = 0.
  - `rx_en` = 0, `cmd_valid` = 0, `cmd_code` = 0, `cmd_count` = 0, `overflow` = 0.
  - Reset asserted mid-sequence or mid-FIFO discards all state.

## Timing
- `rx_en` rises on the first `clk` edge after `reset` deasserts.
- Command latency: a decoding byte with `rx_done_tick` in cycle N gives `cmd_valid` = 1 and `cmd_code` valid in cycle N+1.
- Pop: with `cmd_rd` in cycle N, the next entry (or `cmd_valid` = 0) appears in cycle N+1. `cmd_count` updates in the same cycle N+1.
- `cmd_valid`, `cmd_code` and `cmd_count` are driven from registers and FIFO storage only, with no combinational path from `rx_data` or `cmd_rd`.
- Back-to-back `rx_done_tick` on consecutive cycles are fully supported.

## Test plan
- After reset release, send F0,2B -> `rx_en` = 1 from cycle 1; `cmd_valid` = 1 and `cmd_code` = 1 one cycle after the 2B tick; `cmd_count` = 1. Pulse `cmd_rd` -> `cmd_valid` = 0 the next cycle.
- Send E0,75 then E0,F0,75, then the keypad sequence 72,F0,72 -> exactly two commands, 4 then 7. Make codes produce nothing.
- Send F0,2C; E0,F0,74; F0,76; F0,33 with no reads -> FIFO holds 3,5,8,2; `cmd_count` = 4; `rx_en` = 0. Send F0,6B -> `overflow` = 1 and the contents are unchanged. Pulse `cmd_rd` -> `rx_en` = 1 the next cycle. Pulse `ovf_clr` -> `overflow` = 0.
- FIFO full and F0,6B decoded in the same cycle as `cmd_rd` -> count stays 4, `overflow` stays 0, entry order 5,8,2,6.
- Send F0, then wait TIMEOUT cycles (use TIMEOUT = 16 in the bench), then 2B -> no command (FSM back in IDLE). Repeat with 2B at TIMEOUT-2 -> command 1.
- Send E0,F0, assert `reset` = 0 for 2 cycles, then send 75 -> no command. All outputs equal their reset values during reset.
